// File: rtl/crypto_pkg.sv
// Shared definitions for the modular-arithmetic pipeline stages.
package crypto_pkg;

  localparam int OP_W   = 128;
  localparam int PROD_W = 2 * OP_W;

  // Common control FSM encoding reused by sibling stages.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stage_state_e;

endpackage : crypto_pkg

// File: rtl/operand_multiplier_if.sv
// Operand / product bundle between the requester, the multiplier and the
// downstream remainder stage.
interface operand_multiplier_if #(
  parameter int WIDTH = crypto_pkg::OP_W
) ();

  logic                   start;
  logic [WIDTH-1:0]       x;
  logic [WIDTH-1:0]       y;
  logic [WIDTH-1:0]       modulus_in;
  logic                   busy;
  logic [2*WIDTH-1:0]     product;
  logic                   dividend_valid;
  logic [WIDTH-1:0]       modulus_out;
  logic                   divisor_valid;

  // Requester side: issues operands, observes results.
  modport master (
    output start, x, y, modulus_in,
    input  busy, product, dividend_valid, modulus_out, divisor_valid
  );

  // Multiplier side.
  modport slave (
    input  start, x, y, modulus_in,
    output busy, product, dividend_valid, modulus_out, divisor_valid
  );

endinterface : operand_multiplier_if

// File: rtl/operand_multiplier_mul_step.sv
// One shift-add iteration: conditionally add the multiplicand into the high
// half (keeping the carry), then shift the whole {sum, lo} right by one.
module operand_multiplier_mul_step #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;

  // Carry bit lands in the top of hi after the shift, so nothing is lost.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    hi_next = sum[WIDTH:1];
    lo_next = {sum[0], lo[WIDTH-1:1]};
  end

endmodule : operand_multiplier_mul_step

// File: rtl/operand_multiplier.sv
// Sequential shift-add multiplier producing the 2*WIDTH-bit dividend and the
// captured modulus for the remainder stage, with coincident valid pulses.
module operand_multiplier
  import crypto_pkg::*;
#(
  parameter int WIDTH = OP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  operand_multiplier_if.slave  bus
);

  localparam int                CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  stage_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, mcand_q, mod_q;
  logic [WIDTH-1:0] hi_step, lo_step;
  logic             valid_q, busy_q;
  logic             load, step;

  operand_multiplier_mul_step #(.WIDTH(WIDTH)) u_mul_step (
    .hi      (hi_q),
    .lo      (lo_q),
    .mcand   (mcand_q),
    .hi_next (hi_step),
    .lo_next (lo_step)
  );

  // Next-state and datapath enables; start outside IDLE is simply ignored.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter, datapath and registered status flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      // NOTE: datapath registers are cleared too, because product and modulus_out must read 0 after reset.
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      mod_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      valid_q <= (state_d == DONE);
      if (load) begin
        hi_q    <= '0;
        lo_q    <= bus.y;
        mcand_q <= bus.x;
        mod_q   <= bus.modulus_in;
        cnt_q   <= '0;
      end else if (step) begin
        hi_q    <= hi_step;
        lo_q    <= lo_step;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Both valids come from one register so they can never skew.
  assign bus.product        = {hi_q, lo_q};
  assign bus.modulus_out    = mod_q;
  assign bus.dividend_valid = valid_q;
  assign bus.divisor_valid  = valid_q;
  assign bus.busy           = busy_q;

endmodule : operand_multiplier

// File: tb/tb_operand_multiplier.sv
// Randomized scoreboard bench for operand_multiplier.
module tb_operand_multiplier;
  import crypto_pkg::*;

  localparam int W   = OP_W;
  localparam int LAT = W + 1;   // edges from the cycle start is driven to the DONE cycle
  localparam int PER = W + 2;   // accept-to-accept spacing

  typedef struct {
    logic [PROD_W-1:0] prod;
    logic [W-1:0]      modv;
    int                due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  operand_multiplier_if #(.WIDTH(W)) bus ();

  operand_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #(2000000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [PROD_W-1:0] act,
                       input logic [PROD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at edge %0d", name, edge_cnt);
  endtask

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: the exact product by plain arithmetic.
  function automatic logic [PROD_W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    return PROD_W'(a) * PROD_W'(b);
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.dividend_valid || bus.divisor_valid) begin
      check("valid_pair", PROD_W'(bus.dividend_valid), PROD_W'(bus.divisor_valid));
      if (sb.size() == 0) begin
        fail("unexpected_pulse");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("product", bus.product, e.prod);
        check("modulus_out", PROD_W'(bus.modulus_out), PROD_W'(e.modv));
        check("pulse_time", PROD_W'(edge_cnt), PROD_W'(e.due));
        check("busy_in_done", PROD_W'(bus.busy), PROD_W'(1'b1));
      end
    end
  end

  // Issue one request from IDLE; returns at the negedge after acceptance.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    exp_t e;
    @(negedge clk);
    bus.x          = a;
    bus.y          = b;
    bus.modulus_in = m;
    bus.start      = 1'b1;
    e.prod = ref_mul(a, b);
    e.modv = m;
    e.due  = edge_cnt + LAT;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.x     = rnd128();
    bus.y     = rnd128();
    check("busy_after_start", PROD_W'(bus.busy), PROD_W'(1'b1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 2 * PER) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      fail("pulse_timeout");
      sb.delete();
    end
  endtask

  // Full operation, then confirm results hold in IDLE.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    issue(a, b, m);
    wait_drain();
    repeat (4) @(negedge clk);
    check("hold_product", bus.product, ref_mul(a, b));
    check("hold_modulus", PROD_W'(bus.modulus_out), PROD_W'(m));
    check("idle_busy", PROD_W'(bus.busy), '0);
  endtask

  initial begin
    logic [W-1:0] a, b, m;
    int t0;
    int accepted;
    int next_acc;

    bus.start      = 1'b0;
    bus.x          = '0;
    bus.y          = '0;
    bus.modulus_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", PROD_W'(bus.busy), '0);
    check("rst_product", bus.product, '0);
    check("rst_modulus", PROD_W'(bus.modulus_out), '0);
    check("rst_dvalid", PROD_W'(bus.dividend_valid), '0);
    check("rst_mvalid", PROD_W'(bus.divisor_valid), '0);
    rst = 1'b0;

    // Directed cases
    op(W'(3), W'(5), W'(7));
    a = '1;
    op(a, a, W'(11));
    op('0, W'(32'hDEADBEEF), W'(13));
    b = W'(1) << (W - 1);
    op(W'(1), b, '0);

    // Starts during RUN and in DONE are ignored
    issue(W'(6), W'(7), W'(99));
    t0 = edge_cnt;
    repeat (9) @(negedge clk);
    bus.x = W'(9); bus.y = W'(9); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (edge_cnt < t0 + W) @(negedge clk);
    bus.x = W'(9); bus.y = W'(9); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    check("ignored_busy", PROD_W'(bus.busy), '0);
    check("ignored_product", bus.product, PROD_W'(42));

    // Reset mid-RUN aborts with no pulse
    issue(rnd128(), rnd128(), rnd128());
    t0 = edge_cnt;
    while (edge_cnt < t0 + 63) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("abort_busy", PROD_W'(bus.busy), '0);
    check("abort_product", bus.product, '0);
    check("abort_modulus", PROD_W'(bus.modulus_out), '0);
    check("abort_valid", PROD_W'(bus.dividend_valid | bus.divisor_valid), '0);
    repeat (PER + 20) @(negedge clk);
    check("abort_idle_busy", PROD_W'(bus.busy), '0);
    op(W'(123456789), W'(987654321), W'(5));

    // Random operands
    for (int i = 0; i < 6; i++) begin
      a = rnd128();
      b = rnd128();
      m = rnd128();
      if (i == 1) a = '1;
      if (i == 2) b = '1;
      op(a, b, m);
    end

    // Back-to-back with start held high; operands change every cycle
    accepted = 0;
    @(negedge clk);
    bus.start = 1'b1;
    next_acc  = edge_cnt + 1;
    while (accepted < 3) begin
      bus.x          = rnd128();
      bus.y          = rnd128();
      bus.modulus_in = rnd128();
      if (edge_cnt + 1 == next_acc) begin
        exp_t e;
        e.prod = ref_mul(bus.x, bus.y);
        e.modv = bus.modulus_in;
        e.due  = edge_cnt + LAT;
        sb.push_back(e);
        accepted++;
        next_acc += PER;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_drain();
    repeat (5) @(negedge clk);
    check("final_busy", PROD_W'(bus.busy), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_operand_multiplier
